// File: rtl/xor3_response_checker_if.sv
// Bundle of signals between the response checker and the gate under test / controller.
interface xor3_response_checker_if #(
  parameter int N_INPUTS  = 3,
  parameter int ERR_CNT_W = 4
);
  logic                 start;
  logic                 dut_out;
  logic [N_INPUTS-1:0]  stim;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [ERR_CNT_W-1:0] err_count;
  logic                 first_fail_valid;
  logic [N_INPUTS-1:0]  first_fail_vec;

  // Checker side: takes the start request and the gate output, drives everything else.
  modport slave (
    input  start, dut_out,
    output stim, busy, done, pass, err_count, first_fail_valid, first_fail_vec
  );

  // Controller / gate side.
  modport master (
    output start, dut_out,
    input  stim, busy, done, pass, err_count, first_fail_valid, first_fail_vec
  );
endinterface

// File: rtl/xor3_response_checker.sv
// Exhaustive sweep checker for an XOR (parity) gate: drives every input vector,
// waits for it to settle, compares the gate output against the expected parity,
// and records pass/fail, a saturating mismatch count and the first failing vector.
module xor3_response_checker #(
  parameter int N_INPUTS      = 3,
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_CNT_W     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  xor3_response_checker_if.slave  bus
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [N_INPUTS-1:0]  stim;
  logic [ERR_CNT_W-1:0] err_count;
  logic                 pass;
  logic                 first_fail_valid;
  logic [N_INPUTS-1:0]  first_fail_vec;

  logic accept;
  logic in_check;
  logic stim_last;
  logic mismatch;

  // Mismatch counter never wraps; it sticks at all-ones.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign accept    = bus.start && ((state == IDLE) || (state == DONE));
  assign in_check  = (state == CHECK);
  assign stim_last = &stim;
  assign mismatch  = in_check && (bus.dut_out != ^stim);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: settle for SETTLE_CYCLES, one check cycle, repeat until the last vector.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (bus.start) state_nxt = SETTLE;
      SETTLE:     if (cnt == CNT_LAST) state_nxt = CHECK;
      CHECK:      state_nxt = stim_last ? DONE : SETTLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Stimulus, settle counter and result bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt              <= '0;
      stim             <= '0;
      err_count        <= '0;
      pass             <= 1'b0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else begin
      if (state == SETTLE) cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      else                 cnt <= '0;

      if (accept) begin
        stim             <= '0;
        err_count        <= '0;
        pass             <= 1'b0;
        first_fail_valid <= 1'b0;
        first_fail_vec   <= '0;
      end else if (in_check) begin
        if (mismatch) err_count <= sat_inc(err_count);
        if (mismatch && !first_fail_valid) begin
          first_fail_valid <= 1'b1;
          first_fail_vec   <= stim;
        end
        // The last vector holds stim and settles the verdict, including this check.
        if (!stim_last) stim <= stim + 1'b1;
        else            pass <= !first_fail_valid && !mismatch;
      end
    end
  end

  assign bus.stim             = stim;
  assign bus.busy             = (state == SETTLE) || (state == CHECK);
  assign bus.done             = (state == DONE);
  assign bus.pass             = pass;
  assign bus.err_count        = err_count;
  assign bus.first_fail_valid = first_fail_valid;
  assign bus.first_fail_vec   = first_fail_vec;

endmodule

// File: tb/tb_xor3_response_checker.sv
// Directed bench for xor3_response_checker: default instance (a), a narrow
// error counter instance (b) and a 4-input / 1-settle-cycle instance (c).
module tb_xor3_response_checker;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  xor3_response_checker_if #(.N_INPUTS(3), .ERR_CNT_W(4)) ifa ();
  xor3_response_checker_if #(.N_INPUTS(3), .ERR_CNT_W(2)) ifb ();
  xor3_response_checker_if #(.N_INPUTS(4), .ERR_CNT_W(4)) ifc ();

  xor3_response_checker #(.N_INPUTS(3), .SETTLE_CYCLES(2), .ERR_CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave));
  xor3_response_checker #(.N_INPUTS(3), .SETTLE_CYCLES(2), .ERR_CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave));
  xor3_response_checker #(.N_INPUTS(4), .SETTLE_CYCLES(1), .ERR_CNT_W(4)) dut_c (
    .clk(clk), .reset(reset), .bus(ifc.slave));

  // Gate models: 0 = correct XOR, 1 = stuck at 0, 2 = inverted XOR.
  int mode_a = 0, mode_b = 0, mode_c = 0;
  always_comb ifa.dut_out = (mode_a == 0) ? ^ifa.stim : (mode_a == 1) ? 1'b0 : ~^ifa.stim;
  always_comb ifb.dut_out = (mode_b == 0) ? ^ifb.stim : (mode_b == 1) ? 1'b0 : ~^ifb.stim;
  always_comb ifc.dut_out = (mode_c == 0) ? ^ifc.stim : (mode_c == 1) ? 1'b0 : ~^ifc.stim;

  int vectors = 0;
  int miscompares = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start on the selected instance and count edges until done (bounded).
  task automatic sweep(input int which, output int cyc);
    case (which)
      0: ifa.start = 1'b1;
      1: ifb.start = 1'b1;
      default: ifc.start = 1'b1;
    endcase
    tick();
    ifa.start = 1'b0; ifb.start = 1'b0; ifc.start = 1'b0;
    cyc = 0;
    while (cyc < 100) begin
      if ((which == 0 && ifa.done) || (which == 1 && ifb.done) || (which == 2 && ifc.done)) break;
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ifa.start = 1'b0; ifb.start = 1'b0; ifc.start = 1'b0;
    repeat (2) tick();
    vectors++; if (ifa.stim !== 3'd0) begin miscompares++; $display("FAIL reset_stim: got %0d expected 0", ifa.stim); end
    vectors++; if (ifa.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b expected 0", ifa.busy); end
    vectors++; if (ifa.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %0b expected 0", ifa.done); end
    vectors++; if (ifa.pass !== 1'b0) begin miscompares++; $display("FAIL reset_pass: got %0b expected 0", ifa.pass); end
    vectors++; if (ifa.err_count !== 4'd0) begin miscompares++; $display("FAIL reset_err: got %0d expected 0", ifa.err_count); end
    vectors++; if (ifa.first_fail_valid !== 1'b0 || ifa.first_fail_vec !== 3'd0) begin miscompares++; $display("FAIL reset_first_fail: got valid=%0b vec=%0d expected 0/0", ifa.first_fail_valid, ifa.first_fail_vec); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_correct_gate();
    int cyc;
    logic [2:0] exp_stim;
    mode_a = 0;
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    cyc = 0;
    while (!ifa.done && cyc < 100) begin
      exp_stim = 3'(cyc / 3);
      vectors++; if (ifa.stim !== exp_stim) begin miscompares++; $display("FAIL correct_stim@%0d: got %0d expected %0d", cyc, ifa.stim, exp_stim); end
      vectors++; if (ifa.busy !== 1'b1) begin miscompares++; $display("FAIL correct_busy@%0d: got %0b expected 1", cyc, ifa.busy); end
      tick();
      cyc++;
    end
    vectors++; if (cyc !== 24) begin miscompares++; $display("FAIL correct_latency: got %0d expected 24", cyc); end
    vectors++; if (ifa.pass !== 1'b1) begin miscompares++; $display("FAIL correct_pass: got %0b expected 1", ifa.pass); end
    vectors++; if (ifa.err_count !== 4'd0) begin miscompares++; $display("FAIL correct_err: got %0d expected 0", ifa.err_count); end
    vectors++; if (ifa.first_fail_valid !== 1'b0) begin miscompares++; $display("FAIL correct_ffv: got %0b expected 0", ifa.first_fail_valid); end
    vectors++; if (ifa.stim !== 3'd7 || ifa.busy !== 1'b0) begin miscompares++; $display("FAIL correct_final: got stim=%0d busy=%0b expected 7/0", ifa.stim, ifa.busy); end
    tick();
    vectors++; if (ifa.done !== 1'b1 || ifa.stim !== 3'd7) begin miscompares++; $display("FAIL correct_hold: got done=%0b stim=%0d expected 1/7", ifa.done, ifa.stim); end
  endtask

  task automatic test_stuck_zero();
    int cyc;
    mode_a = 1;
    sweep(0, cyc);
    vectors++; if (cyc !== 24) begin miscompares++; $display("FAIL stuck0_latency: got %0d expected 24", cyc); end
    vectors++; if (ifa.err_count !== 4'd4) begin miscompares++; $display("FAIL stuck0_err: got %0d expected 4", ifa.err_count); end
    vectors++; if (ifa.pass !== 1'b0) begin miscompares++; $display("FAIL stuck0_pass: got %0b expected 0", ifa.pass); end
    vectors++; if (ifa.first_fail_valid !== 1'b1 || ifa.first_fail_vec !== 3'b001) begin miscompares++; $display("FAIL stuck0_first: got valid=%0b vec=%0d expected 1/1", ifa.first_fail_valid, ifa.first_fail_vec); end
  endtask

  task automatic test_inverted();
    int cyc;
    mode_a = 2;
    sweep(0, cyc);
    vectors++; if (ifa.err_count !== 4'd8) begin miscompares++; $display("FAIL inv_err: got %0d expected 8", ifa.err_count); end
    vectors++; if (ifa.first_fail_valid !== 1'b1 || ifa.first_fail_vec !== 3'b000) begin miscompares++; $display("FAIL inv_first: got valid=%0b vec=%0d expected 1/0", ifa.first_fail_valid, ifa.first_fail_vec); end
    vectors++; if (ifa.pass !== 1'b0) begin miscompares++; $display("FAIL inv_pass: got %0b expected 0", ifa.pass); end
    mode_b = 2;
    sweep(1, cyc);
    vectors++; if (cyc !== 24) begin miscompares++; $display("FAIL inv_sat_latency: got %0d expected 24", cyc); end
    vectors++; if (ifb.err_count !== 2'd3) begin miscompares++; $display("FAIL inv_sat_err: got %0d expected 3", ifb.err_count); end
    vectors++; if (ifb.pass !== 1'b0) begin miscompares++; $display("FAIL inv_sat_pass: got %0b expected 0", ifb.pass); end
  endtask

  task automatic test_start_ignored();
    int cyc;
    mode_a = 0;
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    cyc = 0;
    while (!ifa.done && cyc < 100) begin
      ifa.start = (cyc == 5 || cyc == 10);
      tick();
      cyc++;
    end
    ifa.start = 1'b0;
    vectors++; if (cyc !== 24) begin miscompares++; $display("FAIL ignore_latency: got %0d expected 24", cyc); end
    vectors++; if (ifa.pass !== 1'b1 || ifa.err_count !== 4'd0) begin miscompares++; $display("FAIL ignore_result: got pass=%0b err=%0d expected 1/0", ifa.pass, ifa.err_count); end
  endtask

  task automatic test_restart_after_done();
    int cyc;
    mode_a = 1;
    sweep(0, cyc);
    vectors++; if (ifa.err_count !== 4'd4 || ifa.done !== 1'b1) begin miscompares++; $display("FAIL restart_pre: got err=%0d done=%0b expected 4/1", ifa.err_count, ifa.done); end
    mode_a = 0;
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    vectors++; if (ifa.done !== 1'b0 || ifa.pass !== 1'b0 || ifa.err_count !== 4'd0) begin miscompares++; $display("FAIL restart_clear: got done=%0b pass=%0b err=%0d expected 0/0/0", ifa.done, ifa.pass, ifa.err_count); end
    vectors++; if (ifa.first_fail_valid !== 1'b0 || ifa.busy !== 1'b1 || ifa.stim !== 3'd0) begin miscompares++; $display("FAIL restart_state: got ffv=%0b busy=%0b stim=%0d expected 0/1/0", ifa.first_fail_valid, ifa.busy, ifa.stim); end
    cyc = 0;
    while (!ifa.done && cyc < 100) begin tick(); cyc++; end
    vectors++; if (cyc !== 24 || ifa.pass !== 1'b1) begin miscompares++; $display("FAIL restart_sweep: got cycles=%0d pass=%0b expected 24/1", cyc, ifa.pass); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    mode_a = 0;
    ifa.start = 1'b1;
    tick();
    cyc = 0;
    while (!ifa.done && cyc < 100) begin tick(); cyc++; end
    vectors++; if (cyc !== 24) begin miscompares++; $display("FAIL b2b_first: got %0d expected 24", cyc); end
    tick();
    vectors++; if (ifa.done !== 1'b0 || ifa.busy !== 1'b1 || ifa.stim !== 3'd0) begin miscompares++; $display("FAIL b2b_restart: got done=%0b busy=%0b stim=%0d expected 0/1/0", ifa.done, ifa.busy, ifa.stim); end
    ifa.start = 1'b0;
    cyc = 0;
    while (!ifa.done && cyc < 100) begin tick(); cyc++; end
    vectors++; if (cyc !== 24 || ifa.pass !== 1'b1) begin miscompares++; $display("FAIL b2b_second: got cycles=%0d pass=%0b expected 24/1", cyc, ifa.pass); end
  endtask

  task automatic test_async_reset();
    int cyc;
    mode_a = 1;
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    repeat (13) tick();
    vectors++; if (ifa.stim !== 3'd4 || ifa.err_count === 4'd0) begin miscompares++; $display("FAIL areset_pre: got stim=%0d err=%0d expected 4/nonzero", ifa.stim, ifa.err_count); end
    #2 reset = 1'b1;
    #1;
    vectors++; if (ifa.stim !== 3'd0 || ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin miscompares++; $display("FAIL areset_ctrl: got stim=%0d busy=%0b done=%0b expected 0/0/0", ifa.stim, ifa.busy, ifa.done); end
    vectors++; if (ifa.err_count !== 4'd0 || ifa.first_fail_valid !== 1'b0 || ifa.first_fail_vec !== 3'd0 || ifa.pass !== 1'b0) begin miscompares++; $display("FAIL areset_result: got err=%0d ffv=%0b ffvec=%0d pass=%0b expected 0", ifa.err_count, ifa.first_fail_valid, ifa.first_fail_vec, ifa.pass); end
    #1 reset = 1'b0;
    repeat (2) tick();
    vectors++; if (ifa.busy !== 1'b0 || ifa.done !== 1'b0 || ifa.stim !== 3'd0) begin miscompares++; $display("FAIL areset_idle: got busy=%0b done=%0b stim=%0d expected 0/0/0", ifa.busy, ifa.done, ifa.stim); end
    mode_a = 0;
    sweep(0, cyc);
    vectors++; if (cyc !== 24 || ifa.pass !== 1'b1) begin miscompares++; $display("FAIL areset_sweep: got cycles=%0d pass=%0b expected 24/1", cyc, ifa.pass); end
  endtask

  task automatic test_wide_fast();
    int cyc;
    mode_c = 0;
    sweep(2, cyc);
    vectors++; if (cyc !== 32) begin miscompares++; $display("FAIL wide_latency: got %0d expected 32", cyc); end
    vectors++; if (ifc.pass !== 1'b1 || ifc.err_count !== 4'd0) begin miscompares++; $display("FAIL wide_result: got pass=%0b err=%0d expected 1/0", ifc.pass, ifc.err_count); end
    vectors++; if (ifc.stim !== 4'd15) begin miscompares++; $display("FAIL wide_stim: got %0d expected 15", ifc.stim); end
    mode_c = 1;
    sweep(2, cyc);
    vectors++; if (ifc.err_count !== 4'd8 || ifc.first_fail_vec !== 4'd1) begin miscompares++; $display("FAIL wide_stuck0: got err=%0d ffvec=%0d expected 8/1", ifc.err_count, ifc.first_fail_vec); end
  endtask

  initial begin
    test_reset();
    test_correct_gate();
    test_stuck_zero();
    test_inverted();
    test_start_ignored();
    test_restart_after_done();
    test_back_to_back();
    test_async_reset();
    test_wide_fast();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
